// File: rtl/block_stream_gen.sv
// Serializes queued begin/end/filler token commands as ASCII bytes under valid/ready
// and tracks the nesting depth of the words it has emitted.
module block_stream_gen #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_upper,
    output logic        cmd_ready,
    output logic [7:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] depth,
    output logic        balanced,
    output logic        underflow,
    output logic        idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [1:0] OP_BEGIN = 2'b00;
    localparam logic [1:0] OP_END   = 2'b01;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    function automatic logic [2:0] last_idx(input logic [1:0] op);
        case (op)
            OP_BEGIN: return 3'd5;
            OP_END:   return 3'd3;
            default:  return 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] char_of(input logic [1:0] op, input logic upper,
                                           input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h20;
        case (op)
            OP_BEGIN: case (idx)
                3'd0:    c = 8'h62;
                3'd1:    c = 8'h65;
                3'd2:    c = 8'h67;
                3'd3:    c = 8'h69;
                3'd4:    c = 8'h6E;
                default: c = 8'h20;
            endcase
            OP_END: case (idx)
                3'd0:    c = 8'h65;
                3'd1:    c = 8'h6E;
                3'd2:    c = 8'h64;
                default: c = 8'h20;
            endcase
            default: c = (idx == 3'd0) ? 8'h78 : 8'h20;
        endcase
        // Upper-casing clears bit 5 of letters only; the space byte stays 0x20.
        if (upper && c != 8'h20) c[5] = 1'b0;
        return c;
    endfunction

    // Command FIFO
    logic [2:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_w, empty_w, push_w, pop_w;
    logic [2:0]    rd_entry;
    logic [1:0]    rd_op;
    logic          rd_upper;

    // Serializer state
    state_t        state_q;
    logic [2:0]    idx_q;
    logic [1:0]    op_q;
    logic          upper_q;
    logic [7:0]    out_char_q;
    logic          out_valid_q;
    logic [31:0]   depth_q, depth_d;
    logic          underflow_q, underflow_d;
    logic          last_w;

    assign full_w   = (count_q == FULL_CNT);
    assign empty_w  = (count_q == '0);
    assign push_w   = cmd_valid && !full_w;
    assign last_w   = (idx_q == last_idx(op_q));
    assign pop_w    = !empty_w && ((state_q == S_IDLE) || (out_ready && last_w));
    assign rd_entry = fifo_mem[rd_ptr_q];
    assign rd_op    = rd_entry[2:1];
    assign rd_upper = rd_entry[0];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_w) fifo_mem[wr_ptr_q] <= {cmd_op, cmd_upper};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Depth freezes once negative; an end word at depth 0 is what drives it negative.
    always_comb begin
        depth_d     = depth_q;
        underflow_d = underflow_q;
        if (!depth_q[31]) begin
            if (op_q == OP_BEGIN) begin
                depth_d = depth_q + 32'd1;
            end else if (op_q == OP_END) begin
                depth_d = depth_q - 32'd1;
                if (depth_q == 32'd0) underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            op_q        <= 2'b00;
            upper_q     <= 1'b0;
            out_char_q  <= 8'h00;
            out_valid_q <= 1'b0;
            depth_q     <= 32'd0;
            underflow_q <= 1'b0;
        end else begin
            if (state_q == S_EMIT && out_ready) begin
                if (!last_w) begin
                    idx_q      <= idx_q + 3'd1;
                    out_char_q <= char_of(op_q, upper_q, idx_q + 3'd1);
                end else begin
                    depth_q     <= depth_d;
                    underflow_q <= underflow_d;
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    out_char_q  <= 8'h00;
                end
            end
            // A pop overrides the return to IDLE above, so back-to-back words have no bubble.
            if (pop_w) begin
                state_q     <= S_EMIT;
                op_q        <= rd_op;
                upper_q     <= rd_upper;
                idx_q       <= 3'd0;
                out_char_q  <= char_of(rd_op, rd_upper, 3'd0);
                out_valid_q <= 1'b1;
            end
        end
    end

    assign cmd_ready = !full_w;
    assign out_char  = out_char_q;
    assign out_valid = out_valid_q;
    assign depth     = depth_q;
    assign balanced  = (depth_q == 32'd0);
    assign underflow = underflow_q;
    assign idle      = empty_w && (state_q == S_IDLE);

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed bench for block_stream_gen: a table of single-word vectors plus
// hand-written sequences for stall, underflow, FIFO-full and mid-word reset.
module tb_block_stream_gen;
    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_upper;
    logic        cmd_ready;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] depth;
    logic        balanced;
    logic        underflow;
    logic        idle;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic        up;
        logic [47:0] bytes;
        logic [3:0]  len;
        logic [31:0] depth;
        logic        under;
    } vec_t;

    vec_t tbl [7];
    vec_t fq  [5];
    vec_t v;

    block_stream_gen #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_upper (cmd_upper),
        .cmd_ready (cmd_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .depth     (depth),
        .balanced  (balanced),
        .underflow (underflow),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_upper = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic up, input string tag);
        int waited;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_upper = up;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s_accept", tag), 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // One byte per negedge, so any bubble shows up as a miscompare.
    task automatic expect_bytes(input logic [47:0] b, input int len, input string tag);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'({out_valid, out_char}),
                  32'({1'b1, b[47-8*i -: 8]}));
            @(negedge clk);
        end
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp_depth, input logic exp_under);
        check($sformatf("%s_depth", tag), depth, exp_depth);
        check($sformatf("%s_balanced", tag), 32'(balanced), 32'(exp_depth == 32'd0));
        check($sformatf("%s_underflow", tag), 32'(underflow), 32'(exp_under));
    endtask

    task automatic run_word(input vec_t w, input string tag);
        push_cmd(w.op, w.up, tag);
        check($sformatf("%s_lat", tag), 32'(out_valid), 32'd0);
        @(negedge clk);
        expect_bytes(w.bytes, int'(w.len), tag);
        check_status(tag, w.depth, w.under);
        check($sformatf("%s_idle", tag), 32'(idle), 32'd1);
        check($sformatf("%s_vdrop", tag), 32'(out_valid), 32'd0);
    endtask

    initial begin
        tbl[0] = '{op:2'b00, up:1'b0, bytes:48'h626567696E20, len:4'd6, depth:32'd1, under:1'b0};
        tbl[1] = '{op:2'b01, up:1'b0, bytes:48'h656E64200000, len:4'd4, depth:32'd0, under:1'b0};
        tbl[2] = '{op:2'b10, up:1'b0, bytes:48'h782000000000, len:4'd2, depth:32'd0, under:1'b0};
        tbl[3] = '{op:2'b00, up:1'b0, bytes:48'h626567696E20, len:4'd6, depth:32'd1, under:1'b0};
        tbl[4] = '{op:2'b11, up:1'b1, bytes:48'h582000000000, len:4'd2, depth:32'd1, under:1'b0};
        tbl[5] = '{op:2'b01, up:1'b1, bytes:48'h454E44200000, len:4'd4, depth:32'd0, under:1'b0};
        tbl[6] = '{op:2'b00, up:1'b1, bytes:48'h424547494E20, len:4'd6, depth:32'd1, under:1'b0};

        fq[0] = '{op:2'b00, up:1'b0, bytes:48'h626567696E20, len:4'd6, depth:32'd1, under:1'b0};
        fq[1] = '{op:2'b01, up:1'b0, bytes:48'h656E64200000, len:4'd4, depth:32'd0, under:1'b0};
        fq[2] = '{op:2'b10, up:1'b0, bytes:48'h782000000000, len:4'd2, depth:32'd0, under:1'b0};
        fq[3] = '{op:2'b00, up:1'b1, bytes:48'h424547494E20, len:4'd6, depth:32'd1, under:1'b0};
        fq[4] = '{op:2'b01, up:1'b0, bytes:48'h656E64200000, len:4'd4, depth:32'd0, under:1'b0};

        // Reset values
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_char", 32'(out_char), 32'h00);
        check("rst_depth", depth, 32'd0);
        check("rst_balanced", 32'(balanced), 32'd1);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Table: one word at a time, depth carried across entries
        for (int k = 0; k < 7; k++) run_word(tbl[k], $sformatf("tbl%0d", k));

        // Upper-case begin with a 3-cycle stall on the third byte
        do_reset();
        push_cmd(2'b00, 1'b1, "stall");
        check("stall_lat", 32'(out_valid), 32'd0);
        @(negedge clk);
        expect_bytes(48'h424500000000, 2, "stall_head");
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stall_hold%0d", k), 32'({out_valid, out_char}), 32'({1'b1, 8'h47}));
            check($sformatf("stall_depth%0d", k), depth, 32'd0);
            if (k == 3) out_ready = 1'b1;
            @(negedge clk);
        end
        expect_bytes(48'h494E20000000, 3, "stall_tail");
        check_status("stall", 32'd1, 1'b0);

        // end at depth 0 underflows, then depth stays frozen
        do_reset();
        v = '{op:2'b01, up:1'b0, bytes:48'h656E64200000, len:4'd4, depth:32'hFFFF_FFFF, under:1'b1};
        run_word(v, "uf_end");
        v = '{op:2'b00, up:1'b0, bytes:48'h626567696E20, len:4'd6, depth:32'hFFFF_FFFF, under:1'b1};
        run_word(v, "uf_begin");

        // Fill the FIFO with the output stalled; a sixth command is refused
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1;
            cmd_op    = fq[k].op;
            cmd_upper = fq[k].up;
            check($sformatf("fill_rdy%0d", k), 32'(cmd_ready), 32'd1);
            @(negedge clk);
        end
        cmd_op    = 2'b11;
        cmd_upper = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("full_rdy%0d", k), 32'(cmd_ready), 32'd0);
            check($sformatf("full_hold%0d", k), 32'({out_valid, out_char}), 32'({1'b1, 8'h62}));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) expect_bytes(fq[k].bytes, int'(fq[k].len), $sformatf("drain%0d", k));
        check("drain_vdrop", 32'(out_valid), 32'd0);
        check("drain_idle", 32'(idle), 32'd1);
        check_status("drain", 32'd0, 1'b0);
        v = '{op:2'b11, up:1'b1, bytes:48'h582000000000, len:4'd2, depth:32'd0, under:1'b0};
        run_word(v, "reoffer");

        // Reset during the third byte of a begin, with another begin queued
        do_reset();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_upper = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        expect_bytes(48'h626500000000, 2, "mid_head");
        check("mid_b2", 32'({out_valid, out_char}), 32'({1'b1, 8'h67}));
        check("mid_pre_idle", 32'(idle), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_depth", depth, 32'd0);
        check("mid_idle", 32'(idle), 32'd1);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        v = '{op:2'b01, up:1'b0, bytes:48'h656E64200000, len:4'd4, depth:32'hFFFF_FFFF, under:1'b1};
        run_word(v, "mid_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
